// File: rtl/snake_pkg.sv
// Shared types for the snake segment writer.
//   cell_t     : cell codes understood by the grid writer
//   wr_state_t : writer FSM states
//   seg_w()    : packed segment width ({y,x}) for a given coordinate width
package snake_pkg;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_FOOD  = 2'b01,
    CELL_SNAKE = 2'b10,
    CELL_HEAD  = 2'b11
  } cell_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } wr_state_t;

  function automatic int seg_w(input int coord_w);
    return 2 * coord_w;
  endfunction

endpackage

// File: rtl/snake_seg_shifter.sv
// Snapshot register for the snake body.
// The body is captured whole on load and then shifted down one segment per
// accepted transfer, so the segment being presented is always in slot 0.
// That keeps the output path a plain register instead of a MAX_SEG:1 mux.
// Ports:
//   clk, reset : clock, synchronous active-high reset (clears to zero)
//   load       : capture din
//   shift      : drop slot 0, move every segment down one slot
//   din        : packed body, seg i = din[i*SEG_W +: SEG_W]
//   seg_out    : current segment (slot 0)
module snake_seg_shifter #(
  parameter int SEG_W   = 8,
  parameter int MAX_SEG = 225
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic                     shift,
  input  logic [MAX_SEG*SEG_W-1:0] din,
  output logic [SEG_W-1:0]         seg_out
);

  logic [MAX_SEG-1:0][SEG_W-1:0] sr;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      for (int i = 0; i < MAX_SEG - 1; i++) sr[i] <= sr[i+1];
      sr[MAX_SEG-1] <= '0;
    end
  end

  assign seg_out = sr[0];

endmodule

// File: rtl/snake_segment_writer.sv
// Streams a snapshotted snake body to the grid writer, one segment per
// valid/ready transfer, bracketed by a start pulse and a one-cycle done.
// Build option: HEAD_TAG_EN -> segment 0 is tagged CELL_HEAD, the rest
// CELL_SNAKE; without it every segment is CELL_SNAKE.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   start       : begin a frame (only honoured in IDLE)
//   snake_len   : number of valid segments, clipped to MAX_SEG
//   snake_in    : packed body, seg i = {y,x} at [i*SEG_W +: SEG_W]
//   wr_ready    : grid writer accepts the presented segment
//   wr_valid    : x_loc/y_loc/data_out valid
//   x_loc,y_loc : coordinates of the presented segment
//   data_out    : cell code
//   busy        : high in WRITE
//   done        : one-cycle pulse after the last accepted segment
module snake_segment_writer
  import snake_pkg::*;
#(
  parameter int COORD_W = 4,
  parameter int MAX_SEG = 225,
  parameter int LEN_W   = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [LEN_W-1:0]                      snake_len,
  input  logic [MAX_SEG*seg_w(COORD_W)-1:0]     snake_in,
  input  logic                                  wr_ready,
  output logic                                  wr_valid,
  output logic [COORD_W-1:0]                    x_loc,
  output logic [COORD_W-1:0]                    y_loc,
  output logic [1:0]                            data_out,
  output logic                                  busy,
  output logic                                  done
);

  localparam int SEG_W = seg_w(COORD_W);

`ifdef HEAD_TAG_EN
  localparam cell_t FIRST_CELL = CELL_HEAD;
`else
  localparam cell_t FIRST_CELL = CELL_SNAKE;
`endif

  wr_state_t        state, state_nxt;
  logic [LEN_W-1:0] len_q, idx_q;
  logic [SEG_W-1:0] seg_cur;
  logic             load, adv, last, xfer;

  assign xfer = wr_valid && wr_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    adv       = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          // An empty body still produces a done pulse so the caller's
          // handshake completes.
          state_nxt = (snake_len == '0) ? DONE : WRITE;
        end
      end
      WRITE: begin
        if (xfer) begin
          adv  = 1'b1;
          last = (idx_q == len_q - LEN_W'(1));
          if (last) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q    <= '0;
      len_q    <= '0;
      wr_valid <= 1'b0;
      data_out <= CELL_SNAKE;
    end else if (load) begin
      idx_q    <= '0;
      len_q    <= (snake_len > LEN_W'(MAX_SEG)) ? LEN_W'(MAX_SEG) : snake_len;
      wr_valid <= (snake_len != '0);
      data_out <= FIRST_CELL;
    end else if (adv) begin
      idx_q    <= idx_q + LEN_W'(1);
      wr_valid <= !last;
      data_out <= CELL_SNAKE;
    end
  end

  // No shift on the last transfer so the final coordinates stay put.
  snake_seg_shifter #(
    .SEG_W   (SEG_W),
    .MAX_SEG (MAX_SEG)
  ) u_shifter (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .shift   (adv && !last),
    .din     (snake_in),
    .seg_out (seg_cur)
  );

  assign x_loc = seg_cur[COORD_W-1:0];
  assign y_loc = seg_cur[SEG_W-1:COORD_W];
  assign busy  = (state == WRITE);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_snake_segment_writer.sv
module tb_snake_segment_writer;

  localparam int COORD_W = 4;
  localparam int MAX_SEG = 225;
  localparam int LEN_W   = 8;
  localparam int SEG_W   = 2 * COORD_W;

`ifdef HEAD_TAG_EN
  localparam logic [1:0] HEAD_EXP = 2'b11;
`else
  localparam logic [1:0] HEAD_EXP = 2'b10;
`endif
  localparam logic [1:0] BODY_EXP = 2'b10;

  logic                     clk = 1'b0;
  logic                     reset, start, wr_ready;
  logic [LEN_W-1:0]         snake_len;
  logic [MAX_SEG*SEG_W-1:0] snake_in;
  logic                     wr_valid, busy, done;
  logic [COORD_W-1:0]       x_loc, y_loc;
  logic [1:0]               data_out;

  typedef struct {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [1:0]         d;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   xfer_cnt = 0;

  snake_segment_writer #(
    .COORD_W (COORD_W),
    .MAX_SEG (MAX_SEG),
    .LEN_W   (LEN_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .snake_len (snake_len),
    .snake_in  (snake_in),
    .wr_ready  (wr_ready),
    .wr_valid  (wr_valid),
    .x_loc     (x_loc),
    .y_loc     (y_loc),
    .data_out  (data_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, wanted completion");
    $fatal(1, "watchdog");
  end

  // Monitor: every accepted segment must match the next expectation.
  always @(negedge clk) begin
    if (wr_valid && wr_ready && !reset) begin
      checks++;
      xfer_cnt++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_xfer: got x=%0d y=%0d d=%0d, wanted no transfer",
                 x_loc, y_loc, data_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (x_loc !== e.x || y_loc !== e.y || data_out !== e.d) begin
          errors++;
          $display("FAIL seg_data: got x=%0d y=%0d d=%0d, wanted x=%0d y=%0d d=%0d",
                   x_loc, y_loc, data_out, e.x, e.y, e.d);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, wanted %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int x, input int y, input logic [1:0] d);
    exp_t e;
    e.x = COORD_W'(x);
    e.y = COORD_W'(y);
    e.d = d;
    sb.push_back(e);
  endtask

  // seg i = i mod 256: x = low nibble, y = high nibble
  task automatic fill_ramp();
    for (int i = 0; i < MAX_SEG; i++) snake_in[i*SEG_W +: SEG_W] = SEG_W'(i);
  endtask

  task automatic push_ramp(input int n);
    for (int i = 0; i < n; i++) push_exp(i % 16, (i / 16) % 16, (i == 0) ? HEAD_EXP : BODY_EXP);
  endtask

  task automatic set3();
    snake_in = '0;
    snake_in[0*SEG_W +: SEG_W] = 8'h12;
    snake_in[1*SEG_W +: SEG_W] = 8'h34;
    snake_in[2*SEG_W +: SEG_W] = 8'h56;
    snake_len = 8'd3;
  endtask

  task automatic push3();
    push_exp(2, 1, HEAD_EXP);
    push_exp(4, 3, BODY_EXP);
    push_exp(6, 5, BODY_EXP);
  endtask

  // Called #1 after a posedge; start is sampled at the next edge.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int maxc);
    bit seen = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    chk(name, int'(seen), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int base;
    reset = 1'b1; start = 1'b0; wr_ready = 1'b1; snake_len = '0; snake_in = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_wr_valid", int'(wr_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_x", int'(x_loc), 0);
    chk("rst_y", int'(y_loc), 0);
    chk("rst_data", int'(data_out), 2);
    @(posedge clk); #1;

    // 1: basic 3-segment frame, ready held high
    set3(); push3();
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t1_valid", int'(wr_valid), 1);
      chk("t1_busy", int'(busy), 1);
    end
    @(negedge clk);
    chk("t1_done", int'(done), 1);
    chk("t1_valid_drop", int'(wr_valid), 0);
    chk("t1_busy_drop", int'(busy), 0);
    @(negedge clk);
    chk("t1_done_1cyc", int'(done), 0);
    chk("t1_sb_empty", sb.size(), 0);
    @(posedge clk); #1;

    // 2: backpressure, segment 0 held for 5 cycles
    set3(); push3();
    wr_ready = 1'b0;
    pulse_start();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t2_hold_valid", int'(wr_valid), 1);
      chk("t2_hold_x", int'(x_loc), 2);
      chk("t2_hold_y", int'(y_loc), 1);
      chk("t2_hold_d", int'(data_out), int'(HEAD_EXP));
      if (k == 3) begin
        @(posedge clk); #1;
        wr_ready = 1'b1;
      end
    end
    wait_done("t2_done", 10);
    chk("t2_sb_empty", sb.size(), 0);

    // 3a: zero length -> no valid, done at start+1
    snake_len = 8'd0;
    pulse_start();
    @(negedge clk);
    chk("t3_zero_done", int'(done), 1);
    chk("t3_zero_valid", int'(wr_valid), 0);
    @(negedge clk);
    chk("t3_zero_done_off", int'(done), 0);
    @(posedge clk); #1;

    // 3b: over-long length clipped to MAX_SEG
    fill_ramp();
    snake_len = LEN_W'(MAX_SEG + 5);
    push_ramp(MAX_SEG);
    base = xfer_cnt;
    pulse_start();
    wait_done("t3_max_done", MAX_SEG + 20);
    chk("t3_max_xfers", xfer_cnt - base, MAX_SEG);
    chk("t3_max_sb_empty", sb.size(), 0);

    // 4a: inputs changed after the snapshot are not seen
    set3(); push3();
    wr_ready = 1'b0;
    pulse_start();
    snake_in = '1;
    snake_len = 8'd9;
    @(posedge clk); #1;
    wr_ready = 1'b1;
    wait_done("t4_snap_done", 10);
    chk("t4_snap_sb_empty", sb.size(), 0);

    // 4b: second start while busy is dropped
    set3(); push3();
    base = xfer_cnt;
    pulse_start();
    pulse_start();
    wait_done("t4_ign_done", 10);
    repeat (4) begin
      @(negedge clk);
      chk("t4_ign_idle_valid", int'(wr_valid), 0);
    end
    chk("t4_ign_xfers", xfer_cnt - base, 3);
    @(posedge clk); #1;

    // 5: reset after the 2nd transfer of a 10-segment frame
    fill_ramp();
    snake_len = 8'd10;
    push_ramp(2);
    pulse_start();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t5_rst_valid", int'(wr_valid), 0);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_sb_empty", sb.size(), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t5_no_done", int'(done), 0);
    end
    @(posedge clk); #1;
    push_ramp(10);
    pulse_start();
    wait_done("t5_replay_done", 20);
    chk("t5_replay_sb_empty", sb.size(), 0);

    // 6: head tag on a 2-segment frame
    snake_in = '0;
    snake_in[0*SEG_W +: SEG_W] = 8'hA1;
    snake_in[1*SEG_W +: SEG_W] = 8'hB2;
    snake_len = 8'd2;
    push_exp(1, 10, HEAD_EXP);
    push_exp(2, 11, BODY_EXP);
    pulse_start();
    @(negedge clk);
    chk("t6_seg0_data", int'(data_out), int'(HEAD_EXP));
    @(negedge clk);
    chk("t6_seg1_data", int'(data_out), int'(BODY_EXP));
    wait_done("t6_done", 5);
    chk("t6_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
